// File: rtl/neopixel_tx_multi.sv
// -----------------------------------------------------------------------------
// neopixel_tx_multi
//   WS2812/SK6812 serial transmitter. Streams len+1 pixels of BPP bits each,
//   MSB first, from a synchronous pixel RAM. The next pixel is prefetched while
//   the current one is shifted out, so bit periods run back to back across
//   pixel boundaries. Provides busy/done status, abort and auto-repeat.
//
// Ports
//   i_clk       system clock
//   i_reset_n   asynchronous active-low reset
//   i_start     start-frame request, honoured only when idle
//   i_len       pixels in frame minus 1, captured on start
//   i_repeat    sampled in DONE: 1 restarts the frame automatically
//   i_abort     ends the frame early and goes straight to the latch period
//   o_mem_addr  pixel RAM read address (never exceeds the captured length)
//   i_mem_data  RAM read data, valid one cycle after o_mem_addr changes
//   o_led_out   serial data to the LED chain
//   o_busy      high from the start-accept edge until the frame is done
//   o_done      one-cycle pulse when the latch period of a frame completes
// -----------------------------------------------------------------------------
module neopixel_tx_multi #(
  parameter int ADDR_W = 8,
  parameter int BPP    = 24,
  parameter int CNT_W  = 16,
  parameter int T0H    = 8,
  parameter int T0L    = 24,
  parameter int T1H    = 16,
  parameter int T1L    = 16,
  parameter int TRESET = 2200
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_len,
  input  logic              i_repeat,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [BPP-1:0]    i_mem_data,
  output logic              o_led_out,
  output logic              o_busy,
  output logic              o_done
);

  localparam int BIT_W = $clog2(BPP);

  localparam logic [CNT_W-1:0] T0H_M1    = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T0L_M1    = CNT_W'(T0L - 1);
  localparam logic [CNT_W-1:0] T1H_M1    = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] T1L_M1    = CNT_W'(T1L - 1);
  localparam logic [CNT_W-1:0] TRESET_M1 = CNT_W'(TRESET - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(BPP - 1);

  // Timing counters never saturate, so every period must fit in CNT_W bits.
  if (BPP < 2 || CNT_W < 2 ||
      T0H < 1 || T0H >= 2**CNT_W || T0L < 1 || T0L >= 2**CNT_W ||
      T1H < 1 || T1H >= 2**CNT_W || T1L < 1 || T1L >= 2**CNT_W ||
      TRESET < 1 || TRESET >= 2**CNT_W) begin : g_param_check
    $error("neopixel_tx_multi: timing parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HIGH,
    S_LOW,
    S_LATCH,
    S_DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [BPP-1:0]     shift_reg;
  logic [BPP-1:0]     prefetch;
  logic [BIT_W-1:0]   bit_idx;
  logic [ADDR_W-1:0]  pix;
  logic [ADDR_W-1:0]  len_q;

  logic               cur_bit;
  logic [CNT_W-1:0]   high_m1;
  logic [CNT_W-1:0]   low_m1;
  logic               last_bit;
  logic               last_pix;
  logic [ADDR_W:0]    pix_plus2;
  logic               can_advance;

  assign cur_bit     = shift_reg[BPP-1];
  assign high_m1     = cur_bit ? T1H_M1 : T0H_M1;
  assign low_m1      = cur_bit ? T1L_M1 : T0L_M1;
  assign last_bit    = (bit_idx == LAST_BIT);
  assign last_pix    = (pix == len_q);
  // One extra bit so len = 2**ADDR_W-1 cannot wrap the prefetch address to 0.
  assign pix_plus2   = {1'b0, pix} + (ADDR_W+1)'(2);
  assign can_advance = (pix_plus2 <= {1'b0, len_q});
  assign o_done      = (state == S_DONE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks keep every register
      // updating from the same pre-edge values, independent of statement order.
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: assign the default first so no path through the case leaves
    // next_state unassigned, which would infer a latch.
    next_state = state;
    case (state)
      S_IDLE:  if (i_start) next_state = S_FETCH;
      // Cycle 0: RAM reads pixel 0; cycle 1: shift reg loads; cycle 2: first HIGH.
      S_FETCH: begin
        if (i_abort)                 next_state = S_LATCH;
        else if (cnt == CNT_W'(2))   next_state = S_HIGH;
      end
      S_HIGH: begin
        if (i_abort)                 next_state = S_LATCH;
        else if (cnt == high_m1)     next_state = S_LOW;
      end
      S_LOW: begin
        if (i_abort)                 next_state = S_LATCH;
        else if (cnt == low_m1)      next_state = (last_bit && last_pix) ? S_LATCH : S_HIGH;
      end
      S_LATCH: if (cnt == TRESET_M1) next_state = S_DONE;
      S_DONE:  next_state = i_repeat ? S_FETCH : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt        <= '0;
      shift_reg  <= '0;
      prefetch   <= '0;
      bit_idx    <= '0;
      pix        <= '0;
      len_q      <= '0;
      o_mem_addr <= '0;
      o_led_out  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      // The pin is a flop decoded from the next state, so abort and bit
      // transitions take effect on the same edge as the state change.
      o_led_out <= (next_state == S_HIGH);
      o_busy    <= (next_state != S_IDLE);

      if (next_state != state || state == S_IDLE) cnt <= '0;
      else                                        cnt <= cnt + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (i_start) begin
            len_q      <= i_len;
            o_mem_addr <= '0;
          end
        end
        S_FETCH: begin
          if (!i_abort && cnt == CNT_W'(1)) begin
            shift_reg <= i_mem_data;
            pix       <= '0;
            bit_idx   <= '0;
            if (len_q != '0) o_mem_addr <= ADDR_W'(1);
          end
        end
        S_HIGH: prefetch <= i_mem_data;
        S_LOW: begin
          prefetch <= i_mem_data;
          if (next_state == S_HIGH) begin
            if (last_bit) begin
              // Pixel boundary: swap in the prefetched pixel and start the
              // read of the one after it, if it belongs to this frame.
              shift_reg <= prefetch;
              pix       <= pix + ADDR_W'(1);
              bit_idx   <= '0;
              if (can_advance) o_mem_addr <= pix_plus2[ADDR_W-1:0];
            end else begin
              shift_reg <= shift_reg << 1;
              bit_idx   <= bit_idx + BIT_W'(1);
            end
          end
        end
        S_DONE: if (i_repeat) o_mem_addr <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_tx_multi.sv
// -----------------------------------------------------------------------------
// tb_neopixel_tx_multi
//   Bench for neopixel_tx_multi. A 24-bit instance streams frames described by
//   a vector table; expected bits are queued from the bench RAM image at start
//   and a monitor decodes the LED waveform into bits and pops/compares them.
//   A 32-bit instance covers GRBW framing. Hand sequences cover repeat, abort
//   and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_neopixel_tx_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, rpt, abort;
  logic [7:0]  len_in;
  logic [7:0]  mem_addr;
  logic [23:0] mem_data;
  logic        led, busy, done;

  logic        start32;
  logic        rpt32 = 1'b0;
  logic        abort32 = 1'b0;
  logic [7:0]  len32;
  logic [7:0]  addr32;
  logic [31:0] mem_data32;
  logic        led32, busy32, done32;

  logic [23:0] ram   [0:255];
  logic [31:0] ram32 [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neopixel_tx_multi dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_start    (start),
    .i_len      (len_in),
    .i_repeat   (rpt),
    .i_abort    (abort),
    .o_mem_addr (mem_addr),
    .i_mem_data (mem_data),
    .o_led_out  (led),
    .o_busy     (busy),
    .o_done     (done)
  );

  neopixel_tx_multi #(.BPP(32)) dut32 (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_start    (start32),
    .i_len      (len32),
    .i_repeat   (rpt32),
    .i_abort    (abort32),
    .o_mem_addr (addr32),
    .i_mem_data (mem_data32),
    .o_led_out  (led32),
    .o_busy     (busy32),
    .o_done     (done32)
  );

  // Synchronous RAMs: data follows the address one clock later.
  always @(posedge clk) begin
    mem_data   <= ram[mem_addr];
    mem_data32 <= ram32[addr32];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    logic b;
    logic last;
  } exp_bit_t;

  exp_bit_t exp_q[$];
  logic     mon_en = 1'b0;

  task automatic push_frame(input int len);
    logic [23:0] w;
    exp_bit_t    e;
    for (int p = 0; p <= len; p++) begin
      w = ram[p];
      for (int b = 23; b >= 0; b--) begin
        e.b    = w[b];
        e.last = (p == len) && (b == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_ram(input logic [23:0] base, input logic [23:0] step);
    for (int n = 0; n < 256; n++) ram[n] = base + 24'(n) * step;
  endtask

  // Decodes the waveform: each falling edge closes a bit (high time gives its
  // value), the following rising edge closes its low time.
  initial begin : monitor
    logic     mprev;
    int       mrun;
    logic     pend;
    int       pend_exp;
    exp_bit_t e;
    mprev = 1'b0; mrun = 0; pend = 1'b0; pend_exp = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mprev = led; mrun = 0; pend = 1'b0;
      end else if (led === mprev) begin
        mrun++;
      end else begin
        if (mprev === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow actual=bit_seen required=no_bit");
          end else begin
            e = exp_q.pop_front();
            check("bit_high_len", mrun, e.b ? 16 : 8);
            pend     = !e.last;
            pend_exp = e.b ? 16 : 24;
          end
        end else begin
          if (pend) check("bit_low_len", mrun, pend_exp);
          pend = 1'b0;
        end
        mrun  = 1;
        mprev = led;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic meas32(output int h, output int l, output bit to);
    int n;
    to = 1'b0; h = 0; l = 0; n = 0;
    while (led32 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) to = 1'b1;
    while (led32 === 1'b1 && h < 200) begin @(negedge clk); h++; end
    while (led32 !== 1'b1 && busy32 === 1'b1 && l < 3000) begin @(negedge clk); l++; end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int          len;
    logic [23:0] base;
    logic [23:0] step;
    logic        abrt;      // abort driven together with start
    int          exp_lead;  // idle cycles between accept edge and first rise
    int          exp_busy;  // 3 + 32*bits + TRESET + 1
  } vec_t;

  vec_t vecs[3];

  initial begin : main
    int  n, lead, dones, done_idx, max_addr, first_done, gap, highs, h, l;
    bit  rose, to;

    vecs[0] = '{0, 24'hA50000, 24'h000000, 1'b0, 3, 2972};
    vecs[1] = '{7, 24'h000000, 24'h000001, 1'b0, 3, 8348};
    vecs[2] = '{2, 24'h5A5A5A, 24'h123457, 1'b1, 3, 4508};

    rst_n = 1'b0; start = 1'b0; rpt = 1'b0; abort = 1'b0; len_in = '0;
    start32 = 1'b0; len32 = '0;
    for (int i = 0; i < 256; i++) ram32[i] = '0;
    fill_ram(24'h0, 24'h0);

    repeat (3) @(negedge clk);
    check("rst_led",  led,      0);
    check("rst_busy", busy,     0);
    check("rst_done", done,     0);
    check("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- table-driven frames
    for (int v = 0; v < 3; v++) begin
      fill_ram(vecs[v].base, vecs[v].step);
      mon_en = 1'b1;
      @(negedge clk);
      len_in = 8'(vecs[v].len);
      start  = 1'b1;
      abort  = vecs[v].abrt;
      push_frame(vecs[v].len);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      n = 0; lead = 0; rose = 1'b0; dones = 0; done_idx = 0; max_addr = 0;
      while (busy === 1'b1 && n < 20000) begin
        n++;
        if (!rose) begin
          if (led === 1'b1) rose = 1'b1;
          else              lead++;
        end
        if (done === 1'b1) begin dones++; done_idx = n; end
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        start = (n == 50);  // request while busy must be ignored
        @(negedge clk);
      end
      start = 1'b0;
      check($sformatf("v%0d_busy_cycles", v), n,          vecs[v].exp_busy);
      check($sformatf("v%0d_first_rise", v),  lead,       vecs[v].exp_lead);
      check($sformatf("v%0d_done_count", v),  dones,      1);
      check($sformatf("v%0d_done_at_end", v), done_idx,   vecs[v].exp_busy);
      check($sformatf("v%0d_max_addr", v),    max_addr,   vecs[v].len);
      check($sformatf("v%0d_sb_left", v),     exp_q.size(), 0);
      repeat (5) @(negedge clk);
      check($sformatf("v%0d_idle_after", v),  busy,       0);
    end

    // ---------------- auto-repeat, len=1, two frames
    fill_ram(24'h00FF00, 24'h0F0F0F);
    @(negedge clk);
    len_in = 8'd1; start = 1'b1; rpt = 1'b1;
    push_frame(1);
    push_frame(1);
    @(negedge clk);
    start = 1'b0;
    n = 0; dones = 0; first_done = 0; gap = 0;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      if (done === 1'b1) begin
        dones++;
        if (first_done == 0) first_done = n;
      end
      if (first_done != 0 && gap == 0 && led === 1'b1) gap = n - first_done;
      if (first_done != 0 && n == first_done + 10) rpt = 1'b0;
      @(negedge clk);
    end
    rpt = 1'b0;
    check("rep_busy_cycles", n,            7480);
    check("rep_done_count",  dones,        2);
    check("rep_done_to_rise", gap,         4);
    check("rep_sb_left",     exp_q.size(), 0);
    mon_en = 1'b0;

    // ---------------- abort mid pixel 3 of len=7
    fill_ram(24'h0, 24'h1);
    @(negedge clk);
    len_in = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2400) @(negedge clk);
    n = 0;
    while (led !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("abort_led_high_before", led, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_led_next", led,  0);
    check("abort_busy",     busy, 1);
    n = 0; highs = 0; dones = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      if (led === 1'b1)  highs++;
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    check("abort_latch_cycles", n,     2201);
    check("abort_led_highs",    highs, 0);
    check("abort_done_count",   dones, 1);

    // ---------------- 32-bit pixels: all ones then all zeros
    ram32[0] = 32'hFFFF_FFFF;
    ram32[1] = 32'h0;
    @(negedge clk);
    len32 = 8'd1; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      meas32(h, l, to);
      check($sformatf("g32_bit%0d_timeout", i), to, 0);
      check($sformatf("g32_bit%0d_high", i), h, (i < 32) ? 16 : 8);
      if (i < 63) check($sformatf("g32_bit%0d_low", i), l, (i < 32) ? 16 : 24);
      else        check("g32_last_low_plus_latch", l, 24 + 2200 + 1);
    end
    check("g32_idle_after", busy32, 0);

    // ---------------- asynchronous reset during HIGH
    @(negedge clk);
    len_in = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (led !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("rstp_led_high_before", led, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstp_led",  led,      0);
    check("rstp_busy", busy,     0);
    check("rstp_done", done,     0);
    check("rstp_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstp_idle_busy", busy, 0);
    check("rstp_idle_led",  led,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
